// File: rtl/vsd_mount_ctrl.sv
// SD slot mount controller: virtual/physical select, activity LED stretch, core reset after mount.
// Define VSD_MOUNT_RESET_EN to build the mount counter that drives reset_img; otherwise reset_img is 0.
module vsd_mount_ctrl #(
  parameter int NCH     = 2,
  parameter int ACT_TO  = 1000000,
  parameter int RST_LEN = 10000000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [NCH-1:0]   img_mounted,
  input  logic [NCH-1:0]   img_nz,
  input  logic [2*NCH-1:0] act_in,
  output logic [NCH-1:0]   vsd_sel,
  output logic [NCH-1:0]   act,
  output logic             reset_img,
  output logic             led_vsd,
  output logic             led_phys
);

  localparam int AW = $clog2(ACT_TO + 1);

  logic [2*NCH-1:0] act_q;
  logic [AW-1:0]    act_cnt     [NCH];
  logic [AW-1:0]    act_cnt_nxt [NCH];
  logic [NCH-1:0]   act_nxt;

  // act is registered from the next counter value so it rises the cycle after a toggle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      act_cnt_nxt[i] = act_cnt[i];
      if (act_in[2*i +: 2] != act_q[2*i +: 2])
        act_cnt_nxt[i] = AW'(ACT_TO);
      else if (act_cnt[i] != '0)
        act_cnt_nxt[i] = act_cnt[i] - AW'(1);
      act_nxt[i] = (act_cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      act_q   <= '0;
      vsd_sel <= '0;
      act     <= '0;
      for (int i = 0; i < NCH; i++) act_cnt[i] <= '0;
    end else begin
      act_q   <= act_in;
      vsd_sel <= (vsd_sel & ~img_mounted) | (img_nz & img_mounted);
      act     <= act_nxt;
      for (int i = 0; i < NCH; i++) act_cnt[i] <= act_cnt_nxt[i];
    end
  end

`ifdef VSD_MOUNT_RESET_EN
  localparam int RW = $clog2(RST_LEN + 1);

  logic [RW-1:0] mnt_cnt;
  logic [RW-1:0] mnt_cnt_nxt;

  // Any strobe reloads the full window, so back-to-back mounts keep reset_img high.
  always_comb begin
    mnt_cnt_nxt = mnt_cnt;
    if (|img_mounted)
      mnt_cnt_nxt = RW'(RST_LEN);
    else if (mnt_cnt != '0)
      mnt_cnt_nxt = mnt_cnt - RW'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mnt_cnt   <= '0;
      reset_img <= 1'b0;
    end else begin
      mnt_cnt   <= mnt_cnt_nxt;
      reset_img <= (mnt_cnt_nxt != '0);
    end
  end
`else
  assign reset_img = 1'b0;
`endif

  assign led_vsd  = |(act & vsd_sel);
  assign led_phys = |(act & ~vsd_sel);

endmodule

// File: tb/tb_vsd_mount_ctrl.sv
// Bench for vsd_mount_ctrl (NCH=2, ACT_TO=8, RST_LEN=16): timestamp model plus directed literal checks.
module tb_vsd_mount_ctrl;

  localparam int NCH     = 2;
  localparam int ACT_TO  = 8;
  localparam int RST_LEN = 16;
`ifdef VSD_MOUNT_RESET_EN
  localparam logic RI = 1'b1;
`else
  localparam logic RI = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] img_mounted = '0;
  logic [1:0] img_nz = '0;
  logic [3:0] act_in = '0;
  logic [1:0] vsd_sel;
  logic [1:0] act;
  logic       reset_img;
  logic       led_vsd;
  logic       led_phys;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int base = 0;
  bit chk_en = 1'b0;

  vsd_mount_ctrl #(.NCH(NCH), .ACT_TO(ACT_TO), .RST_LEN(RST_LEN)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_nz(img_nz),
    .act_in(act_in), .vsd_sel(vsd_sel), .act(act), .reset_img(reset_img),
    .led_vsd(led_vsd), .led_phys(led_phys)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // Model: remember edge index of last toggle per slot and of last mount strobe.
  bit         tog_seen [2];
  int         tog_last [2];
  bit         mnt_seen;
  int         mnt_last;
  logic [1:0] m_sel;
  logic [3:0] prev_in;

  always @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) tog_seen[i] = 1'b0;
      mnt_seen = 1'b0;
      m_sel    = '0;
      prev_in  = '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (act_in[2*i +: 2] != prev_in[2*i +: 2]) begin
          tog_seen[i] = 1'b1;
          tog_last[i] = cyc;
        end
      prev_in = act_in;
      if (img_mounted != 2'b00) begin
        mnt_seen = 1'b1;
        mnt_last = cyc;
      end
      for (int i = 0; i < 2; i++)
        if (img_mounted[i]) m_sel[i] = img_nz[i];
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc - base + 1, got, exp);
    end
  endtask

  // scoreboard compare on every negedge
  always @(negedge clk_sys) begin
    logic [1:0] e_act;
    logic [1:0] e_sel;
    logic       e_ri;
    if (chk_en) begin
      if (reset) begin
        e_act = '0;
        e_sel = '0;
        e_ri  = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++)
          e_act[i] = tog_seen[i] && ((cyc - 1 - tog_last[i]) < ACT_TO);
        e_sel = m_sel;
        e_ri  = RI && mnt_seen && ((cyc - 1 - mnt_last) < RST_LEN);
      end
      check("m_vsd_sel", {2'b00, vsd_sel}, {2'b00, e_sel});
      check("m_act", {2'b00, act}, {2'b00, e_act});
      check("m_reset_img", {3'b000, reset_img}, {3'b000, e_ri});
      check("m_led_vsd", {3'b000, led_vsd}, {3'b000, |(e_act & e_sel)});
      check("m_led_phys", {3'b000, led_phys}, {3'b000, |(e_act & ~e_sel)});
    end
  end

  // driver tasks
  task automatic wait_edge(input int e);
    while (cyc - base < e) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic at_cycle(input int c);
    wait_edge(c - 1);
    @(negedge clk_sys);
  endtask

  task automatic do_reset(input logic [3:0] a);
    @(posedge clk_sys);
    #1;
    reset       = 1'b1;
    img_mounted = '0;
    img_nz      = '0;
    act_in      = a;
    repeat (3) @(posedge clk_sys);
    #1;
    reset  = 1'b0;
    base   = cyc + 1;
    chk_en = 1'b1;
  endtask

  task automatic strobe(input int e, input logic [1:0] m, input logic [1:0] nz);
    wait_edge(e - 1);
    img_mounted = m;
    img_nz      = nz;
    wait_edge(e);
    img_mounted = '0;
    img_nz      = '0;
  endtask

  task automatic set_act(input int e, input logic [3:0] v);
    wait_edge(e - 1);
    act_in = v;
  endtask

  initial begin
    // reset state
    do_reset(4'b0000);
    at_cycle(1);
    check("rst_vsd_sel", {2'b00, vsd_sel}, 4'b0000);
    check("rst_act", {2'b00, act}, 4'b0000);
    check("rst_reset_img", {3'b000, reset_img}, 4'b0000);

    // single mount strobe, then a simultaneous two-slot strobe
    at_cycle(10);
    check("a_sel_c10", {2'b00, vsd_sel}, 4'b0000);
    strobe(10, 2'b01, 2'b01);
    at_cycle(11);
    check("a_sel_c11", {2'b00, vsd_sel}, 4'b0001);
    check("a_ri_c11", {3'b000, reset_img}, {3'b000, RI});
    at_cycle(26);
    check("a_ri_c26", {3'b000, reset_img}, {3'b000, RI});
    at_cycle(27);
    check("a_ri_c27", {3'b000, reset_img}, 4'b0000);
    strobe(40, 2'b11, 2'b10);
    at_cycle(41);
    check("a_sel_both", {2'b00, vsd_sel}, 4'b0010);

    // retriggered mount window
    do_reset(4'b0000);
    strobe(10, 2'b01, 2'b01);
    strobe(20, 2'b10, 2'b00);
    at_cycle(21);
    check("b_ri_c21", {3'b000, reset_img}, {3'b000, RI});
    at_cycle(36);
    check("b_ri_c36", {3'b000, reset_img}, {3'b000, RI});
    at_cycle(37);
    check("b_ri_c37", {3'b000, reset_img}, 4'b0000);
    check("b_sel", {2'b00, vsd_sel}, 4'b0001);

    // single toggle on a physical slot
    do_reset(4'b0000);
    set_act(5, 4'b0010);
    at_cycle(6);
    check("c_act_c6", {2'b00, act}, 4'b0001);
    check("c_phys_c6", {3'b000, led_phys}, 4'b0001);
    check("c_vsd_c6", {3'b000, led_vsd}, 4'b0000);
    at_cycle(13);
    check("c_act_c13", {2'b00, act}, 4'b0001);
    at_cycle(14);
    check("c_act_c14", {2'b00, act}, 4'b0000);

    // LED rerouting on a select change
    do_reset(4'b0000);
    set_act(3, 4'b0011);
    at_cycle(6);
    check("f_phys_c6", {3'b000, led_phys}, 4'b0001);
    strobe(6, 2'b01, 2'b01);
    at_cycle(7);
    check("f_vsd_c7", {3'b000, led_vsd}, 4'b0001);
    check("f_phys_c7", {3'b000, led_phys}, 4'b0000);

    // continuous toggling on a virtual slot
    do_reset(4'b0000);
    strobe(2, 2'b01, 2'b01);
    for (int k = 0; k < 10; k++) set_act(5 + 4*k, act_in ^ 4'b0001);
    at_cycle(42);
    check("d_vsd_c42", {3'b000, led_vsd}, 4'b0001);
    at_cycle(49);
    check("d_vsd_c49", {3'b000, led_vsd}, 4'b0001);
    at_cycle(50);
    check("d_vsd_c50", {3'b000, led_vsd}, 4'b0000);

    // reset mid-window, act_in held high through release
    do_reset(4'b0000);
    strobe(10, 2'b01, 2'b01);
    wait_edge(14);
    reset  = 1'b1;
    act_in = 4'b0101;
    @(negedge clk_sys);
    check("e_ri_abort", {3'b000, reset_img}, 4'b0000);
    check("e_sel_abort", {2'b00, vsd_sel}, 4'b0000);
    do_reset(4'b0101);
    at_cycle(1);
    check("e_act_c1", {2'b00, act}, 4'b0011);
    at_cycle(8);
    check("e_act_c8", {2'b00, act}, 4'b0011);
    at_cycle(9);
    check("e_act_c9", {2'b00, act}, 4'b0000);
    check("e_ri_c9", {3'b000, reset_img}, 4'b0000);

    wait_edge(12);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vsd_mount_ctrl.md
VSD_MOUNT_CTRL -- requirements
Module: vsd_mount_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of SD slots (1..4).
REQ-002 SHALL have parameter ACT_TO, default 1000000, meaning activity hold time in clk_sys cycles (>=1).
REQ-003 SHALL have parameter RST_LEN, default 10000000, meaning mount-reset pulse length in clk_sys cycles (>=1).
REQ-004 SHALL have port clk_sys  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port img_mounted  in  NCH  one-cycle mount strobe per slot.
REQ-007 SHALL have port img_nz  in  NCH  per slot, image size non-zero; sampled only with that slot's img_mounted.
REQ-008 SHALL have port act_in  in  2*NCH  per slot {miso,mosi} pair watched for toggles; slot i uses bits [2i+1:2i].
REQ-009 SHALL have port vsd_sel  out  NCH  per slot, 1 = virtual image selected, 0 = physical card.
REQ-010 SHALL have port act  out  NCH  per slot, activity-stretched flag.
REQ-011 SHALL have port reset_img  out  1  core reset request after mount.
REQ-012 SHALL have port led_vsd  out  1  OR of act over slots with vsd_sel=1.
REQ-013 SHALL have port led_phys  out  1  OR of act over slots with vsd_sel=0.

Function
REQ-014 Every output SHALL be a registered value, except led_vsd/led_phys, which are combinational from registered vsd_sel and act.
REQ-015 On a cycle with img_mounted[i]=1, vsd_sel[i] SHALL take img_nz[i] at that edge; other slots are unaffected.
REQ-016 Simultaneous strobes on several slots SHALL all update in the same cycle.
REQ-017 Mount counter: on any img_mounted bit, load RST_LEN; else decrement while nonzero; saturates at 0.
REQ-018 reset_img SHALL be high iff the mount counter is nonzero, i.e. high for exactly RST_LEN cycles starting the cycle after the last strobe.
REQ-019 A strobe while reset_img is high SHALL restart the full RST_LEN window (retrigger); no cycle of low is inserted.
REQ-020 Toggle detect: per-slot registered copy of act_in; slot toggle = any bit of the pair differs from its copy.
REQ-021 Per-slot activity counter, width $clog2(ACT_TO+1): toggle loads ACT_TO, else decrement while nonzero.
REQ-022 act[i] SHALL be high iff the counter of slot i is nonzero: high ACT_TO cycles after the last toggle, starting one cycle after the toggle is detected.
REQ-023 Continuous toggling SHALL hold act[i] high indefinitely; counters never wrap.
REQ-024 A vsd_sel change SHALL reroute a slot's act between led_vsd and led_phys in the same cycle as the change.

Reset
REQ-025 Reset SHALL force vsd_sel=0, act=0, reset_img=0, all counters=0 and all act_in copies=0.
REQ-026 An act_in bit already high at reset release SHALL count as a toggle on the first edge after release.
REQ-027 Reset asserted mid-window SHALL abort both the reset_img and act windows immediately, with no residual pulse.

Configuration
REQ-028 Macro VSD_MOUNT_RESET_EN defined: mount counter and reset_img SHALL be implemented per REQ-017..019.
REQ-029 Macro VSD_MOUNT_RESET_EN undefined: the mount counter SHALL be absent and reset_img tied 0; all other behaviour is unchanged.

Verification (NCH=2, ACT_TO=8, RST_LEN=16)
REQ-030 Mount strobe slot0 with img_nz=1 at cycle 10 -> vsd_sel=01 from cycle 11; reset_img high cycles 11..26, low at 27.
REQ-031 Strobe at cycle 10, second strobe slot1 (img_nz=0) at 20 -> reset_img high 11..36 continuously; vsd_sel=01.
REQ-032 Single toggle act_in[1] at cycle 5 -> act=01 for exactly 8 cycles, led_phys high; led_vsd stays 0.
REQ-033 Slot0 selected virtual, toggle act_in[0] every 4 cycles for 40 cycles -> act[0] never drops; led_vsd high throughout, falls 8 cycles after the last toggle.
REQ-034 Reset asserted at cycle 15 inside the REQ-030 window -> reset_img, vsd_sel and act are 0 at once; act_in bits held high through release -> act high on the following 8 cycles.
REQ-035 Build without VSD_MOUNT_RESET_EN, repeat REQ-030 -> vsd_sel=01 from 11; reset_img 0 throughout.
